input_arbiter: RTL and testbench

Sequences and arbitrates the two player-input sources (wired board buttons and the wireless gamepad) ahead of the game logic. It synchronises all inputs and debounces the wired set. It grants control to exactly one source at a time and releases ownership after a period of inactivity. It converts start into a single-cycle event. It replaces plain OR-merging, so the tank controller never sees mixed or bouncing commands from two sources.

---
 rtl/input_arbiter_if.sv | 22 ++
 rtl/input_arbiter.sv | 155 +++++++++++++++
 tb/tb_input_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/input_arbiter_if.sv
// Player-input bundle between the raw button sources and the arbiter.
// The master modport drives the raw buttons; the slave modport is the arbiter side.
interface input_arbiter_if;
    logic       bt_w, bt_s, bt_a, bt_d, bt_st;
    logic       btn_wireless_w, btn_wireless_s, btn_wireless_a, btn_wireless_d, btn_wireless_st;
    logic       btn_w, btn_s, btn_a, btn_d;
    logic       btn_st_pulse;
    logic [1:0] owner;
    logic       conflict;

    modport master (
        output bt_w, bt_s, bt_a, bt_d, bt_st,
        output btn_wireless_w, btn_wireless_s, btn_wireless_a, btn_wireless_d, btn_wireless_st,
        input  btn_w, btn_s, btn_a, btn_d, btn_st_pulse, owner, conflict
    );

    modport slave (
        input  bt_w, bt_s, bt_a, bt_d, bt_st,
        input  btn_wireless_w, btn_wireless_s, btn_wireless_a, btn_wireless_d, btn_wireless_st,
        output btn_w, btn_s, btn_a, btn_d, btn_st_pulse, owner, conflict
    );
endinterface

// File: rtl/input_arbiter.sv
// Wired/wireless player-input arbiter: sync, wired debounce, single-owner grant, start pulse.
// Define INPUT_ARBITER_DEBOUNCE_EN to compile in the wired debounce counters.
module input_arbiter #(
    parameter int DEB_CYCLES  = 1_000_000,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic           clk,
    input  logic           rst,
    input_arbiter_if.slave bus
);
    localparam int                HOLD_W    = $clog2(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WIRED    = 2'b01,
        WIRELESS = 2'b10
    } state_t;

    // Bit order in every 5-bit vector: {st, d, a, s, w}
    logic [4:0] wired_raw, wl_raw;
    logic [4:0] wired_p0, wired_p1, wl_p0, wl_p1;
    logic [4:0] wired_stable;

    assign wired_raw = {bus.bt_st, bus.bt_d, bus.bt_a, bus.bt_s, bus.bt_w};
    assign wl_raw    = {bus.btn_wireless_st, bus.btn_wireless_d, bus.btn_wireless_a,
                        bus.btn_wireless_s, bus.btn_wireless_w};

    // Stage p0/p1: two-flop synchronisers
    always_ff @(posedge clk) begin
        if (rst) begin
            wired_p0 <= '0;
            wired_p1 <= '0;
            wl_p0    <= '0;
            wl_p1    <= '0;
        end else begin
            wired_p0 <= wired_raw;
            wired_p1 <= wired_p0;
            wl_p0    <= wl_raw;
            wl_p1    <= wl_p0;
        end
    end

`ifdef INPUT_ARBITER_DEBOUNCE_EN
    localparam int               DEB_W    = $clog2(DEB_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic [DEB_W-1:0] deb_cnt [5];

    // A change is accepted only after DEB_CYCLES consecutive differing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            wired_stable <= '0;
            for (int i = 0; i < 5; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (wired_p1[i] == wired_stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    wired_stable[i] <= wired_p1[i];
                    deb_cnt[i]      <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    logic deb_cfg_unused;
    assign deb_cfg_unused = (DEB_CYCLES > 1);
    assign wired_stable   = wired_p1;
`endif

    logic              wired_any, wl_any, owner_any;
    state_t            state, next_state;
    logic [HOLD_W-1:0] idle_cnt, idle_cnt_nxt;
    logic [3:0]        btn_q;
    logic              st_q, st_pulse_q, conflict_q, out_active;
    logic              wired_any_q, wl_any_q;
    state_t            owner_q;
    logic [4:0]        gated;
    logic              conflict_nxt;

    assign wired_any  = |wired_stable;
    assign wl_any     = |wl_p1;
    // Inactivity is judged on what the owner is presenting downstream, so the
    // hold window starts on the cycle the owner's outputs fall
    assign out_active = |{btn_q, st_q};

    always_comb begin
        next_state   = state;
        idle_cnt_nxt = idle_cnt;
        owner_any    = 1'b0;
        unique case (state)
            IDLE: begin
                idle_cnt_nxt = '0;
                if (wired_any)   next_state = WIRED;
                else if (wl_any) next_state = WIRELESS;
            end
            WIRED, WIRELESS: begin
                owner_any = (state == WIRED) ? wired_any : wl_any;
                if (out_active) begin
                    idle_cnt_nxt = '0;
                end else if (idle_cnt != HOLD_LAST) begin
                    idle_cnt_nxt = idle_cnt + 1'b1;
                end else if (!owner_any) begin
                    next_state   = IDLE;
                    idle_cnt_nxt = '0;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        gated = '0;
        if (next_state == WIRED)         gated = wired_stable;
        else if (next_state == WIRELESS) gated = wl_p1;
        conflict_nxt = ((state == WIRED)    && wl_any    && !wl_any_q) ||
                       ((state == WIRELESS) && wired_any && !wired_any_q);
    end

    // Stage p2: state and registered outputs, loaded from the next-state decision
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idle_cnt    <= '0;
            owner_q     <= IDLE;
            btn_q       <= '0;
            st_q        <= 1'b0;
            st_pulse_q  <= 1'b0;
            conflict_q  <= 1'b0;
            wired_any_q <= 1'b0;
            wl_any_q    <= 1'b0;
        end else begin
            state       <= next_state;
            idle_cnt    <= idle_cnt_nxt;
            owner_q     <= next_state;
            btn_q       <= gated[3:0];
            st_q        <= gated[4];
            st_pulse_q  <= gated[4] & ~st_q;
            conflict_q  <= conflict_nxt;
            wired_any_q <= wired_any;
            wl_any_q    <= wl_any;
        end
    end

    assign bus.btn_w        = btn_q[0];
    assign bus.btn_s        = btn_q[1];
    assign bus.btn_a        = btn_q[2];
    assign bus.btn_d        = btn_q[3];
    assign bus.btn_st_pulse = st_pulse_q;
    assign bus.owner        = owner_q;
    assign bus.conflict     = conflict_q;
endmodule

// File: tb/tb_input_arbiter.sv
// Directed scoreboard bench for input_arbiter with DEB_CYCLES=4, HOLD_CYCLES=8.
// Expected output vectors are queued against a cycle number and compared on the falling edge.
module tb_input_arbiter;
    localparam int DEB  = 4;
    localparam int HOLD = 8;
`ifdef INPUT_ARBITER_DEBOUNCE_EN
    localparam int WLAT = 3 + DEB;
`else
    localparam int WLAT = 3;
`endif

    typedef struct {
        int         cyc;
        string      tag;
        logic [7:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [7:0] obs;

    input_arbiter_if bus_if ();

    input_arbiter #(.DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // {owner, d, a, s, w, st_pulse, conflict}
    assign obs = {bus_if.owner, bus_if.btn_d, bus_if.btn_a, bus_if.btn_s, bus_if.btn_w,
                  bus_if.btn_st_pulse, bus_if.conflict};

    function automatic logic [7:0] ov(input logic [1:0] o, input logic w, s, a, d, st, cf);
        return {o, d, a, s, w, st, cf};
    endfunction

    task automatic expect_in(input int dly, input string tag, input logic [7:0] val);
        exp_t e;
        int   i;
        e.cyc = cyc + dly;
        e.tag = tag;
        e.val = val;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= e.cyc) i++;
        sb.insert(i, e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            vectors++;
            assert (obs === mon_e.val && mon_e.cyc == cyc) else begin
                miscompares++;
                $error("FAIL %s @cycle %0d (due %0d): observed %h expected %h",
                       mon_e.tag, cyc, mon_e.cyc, obs, mon_e.val);
            end
        end
    end

    initial begin
        {bus_if.bt_w, bus_if.bt_s, bus_if.bt_a, bus_if.bt_d, bus_if.bt_st} = '0;
        {bus_if.btn_wireless_w, bus_if.btn_wireless_s, bus_if.btn_wireless_a,
         bus_if.btn_wireless_d, bus_if.btn_wireless_st} = '0;

        // Reset state
        step(1);
        expect_in(1, "reset_state", 8'h00);
        step(2);
        rst = 1'b0;
        step(2);

        // Wireless press and release
        bus_if.btn_wireless_w = 1'b1;
        expect_in(2, "wl_press_early", 8'h00);
        expect_in(3, "wl_grant", ov(2'b10, 1, 0, 0, 0, 0, 0));
        step(10);
        bus_if.btn_wireless_w = 1'b0;
        expect_in(2,  "wl_still_held", ov(2'b10, 1, 0, 0, 0, 0, 0));
        expect_in(3,  "wl_btn_release", ov(2'b10, 0, 0, 0, 0, 0, 0));
        expect_in(10, "wl_owner_kept", ov(2'b10, 0, 0, 0, 0, 0, 0));
        expect_in(11, "wl_owner_release", 8'h00);
        step(14);

        // Wired glitch of 3 cycles
        bus_if.bt_a = 1'b1;
`ifdef INPUT_ARBITER_DEBOUNCE_EN
        expect_in(3, "glitch_rejected_a", 8'h00);
        expect_in(7, "glitch_rejected_b", 8'h00);
        expect_in(9, "glitch_rejected_c", 8'h00);
`else
        expect_in(3,  "glitch_pass_a", ov(2'b01, 0, 0, 1, 0, 0, 0));
        expect_in(5,  "glitch_pass_b", ov(2'b01, 0, 0, 1, 0, 0, 0));
        expect_in(6,  "glitch_pass_end", ov(2'b01, 0, 0, 0, 0, 0, 0));
        expect_in(13, "glitch_owner_kept", ov(2'b01, 0, 0, 0, 0, 0, 0));
        expect_in(14, "glitch_owner_release", 8'h00);
`endif
        step(3);
        bus_if.bt_a = 1'b0;
        step(13);

        // Wired press held 20 cycles
        bus_if.bt_a = 1'b1;
        expect_in(WLAT - 1, "wired_press_early", 8'h00);
        expect_in(WLAT, "wired_press", ov(2'b01, 0, 0, 1, 0, 0, 0));
        step(20);
        bus_if.bt_a = 1'b0;
        expect_in(WLAT - 1, "wired_hold_last", ov(2'b01, 0, 0, 1, 0, 0, 0));
        expect_in(WLAT, "wired_release", ov(2'b01, 0, 0, 0, 0, 0, 0));
        expect_in(WLAT + 7, "wired_owner_kept", ov(2'b01, 0, 0, 0, 0, 0, 0));
        expect_in(WLAT + 8, "wired_owner_release", 8'h00);
        step(WLAT + 10);

        // Simultaneous activity: wired wins, wireless toggles raise conflict
        bus_if.bt_d = 1'b1;
        step(WLAT - 3);
        bus_if.btn_wireless_s = 1'b1;
        expect_in(2, "simul_early", 8'h00);
        expect_in(3, "simul_grant_wired", ov(2'b01, 0, 0, 0, 1, 0, 0));
        step(5);
        for (int k = 0; k < 2; k++) begin
            bus_if.btn_wireless_s = 1'b0;
            step(2);
            bus_if.btn_wireless_s = 1'b1;
            expect_in(2, "conflict_before", ov(2'b01, 0, 0, 0, 1, 0, 0));
            expect_in(3, "conflict_pulse", ov(2'b01, 0, 0, 0, 1, 0, 1));
            expect_in(4, "conflict_after", ov(2'b01, 0, 0, 0, 1, 0, 0));
            step(5);
        end
        bus_if.bt_d = 1'b0;
        bus_if.btn_wireless_s = 1'b0;
        expect_in(WLAT, "simul_release", ov(2'b01, 0, 0, 0, 0, 0, 0));
        expect_in(WLAT + 8, "simul_owner_release", 8'h00);
        step(WLAT + 12);

        // Start pulse on grant
        bus_if.btn_wireless_st = 1'b1;
        expect_in(2,  "start_early", 8'h00);
        expect_in(3,  "start_grant_pulse", ov(2'b10, 0, 0, 0, 0, 1, 0));
        expect_in(4,  "start_single", ov(2'b10, 0, 0, 0, 0, 0, 0));
        expect_in(10, "start_no_repeat", ov(2'b10, 0, 0, 0, 0, 0, 0));
        step(15);
        bus_if.btn_wireless_st = 1'b0;
        expect_in(10, "start_owner_kept", ov(2'b10, 0, 0, 0, 0, 0, 0));
        expect_in(11, "start_owner_release", 8'h00);
        step(14);

        // Reset mid-operation
        bus_if.bt_w = 1'b1;
        expect_in(WLAT, "rst_pre_grant", ov(2'b01, 1, 0, 0, 0, 0, 0));
        step(WLAT + 2);
        rst = 1'b1;
        expect_in(1, "rst_clears", 8'h00);
        step(1);
        rst = 1'b0;
        expect_in(WLAT - 1, "rst_refresh_early", 8'h00);
        expect_in(WLAT, "rst_refresh", ov(2'b01, 1, 0, 0, 0, 0, 0));
        step(WLAT + 2);
        bus_if.bt_w = 1'b0;
        expect_in(WLAT + 8, "rst_owner_release", 8'h00);
        step(WLAT + 10);

        // Hand-over from wireless to wired
        bus_if.btn_wireless_w = 1'b1;
        expect_in(3, "ho_wl_grant", ov(2'b10, 1, 0, 0, 0, 0, 0));
        step(5);
        bus_if.bt_s = 1'b1;
        expect_in(WLAT, "ho_conflict", ov(2'b10, 1, 0, 0, 0, 0, 1));
        expect_in(WLAT + 1, "ho_conflict_end", ov(2'b10, 1, 0, 0, 0, 0, 0));
        step(WLAT + 2);
        bus_if.btn_wireless_w = 1'b0;
        expect_in(3,  "ho_wl_btn_off", ov(2'b10, 0, 0, 0, 0, 0, 0));
        expect_in(10, "ho_wl_kept", ov(2'b10, 0, 0, 0, 0, 0, 0));
        expect_in(11, "ho_idle_gap", 8'h00);
        expect_in(12, "ho_wired_grant", ov(2'b01, 0, 1, 0, 0, 0, 0));
        step(14);
        bus_if.bt_s = 1'b0;
        expect_in(WLAT, "ho_wired_btn_off", ov(2'b01, 0, 0, 0, 0, 0, 0));
        expect_in(WLAT + 8, "ho_final_release", 8'h00);
        step(WLAT + 12);

        @(posedge clk);
        #1;
        vectors++;
        assert (sb.size() == 0) else begin
            miscompares += sb.size();
            $error("FAIL scoreboard_drain: %0d entries pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
